// File: rtl/pes_sipo_rx.sv
// Serial-in/parallel-out receiver for framed LSB-/MSB-first words with a valid/ready output.
// Optional trailing even-parity bit per frame when PES_RX_PARITY_EN is defined.
module pes_sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_vld,
    input  logic             sof,
    input  logic             dir,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err_frame,
    output logic             err_ovr,
    output logic             par_err
);

    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef PES_RX_PARITY_EN
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(WIDTH);
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             err_frame_q, err_frame_d;
    logic             err_ovr_q, err_ovr_d;
`ifdef PES_RX_PARITY_EN
    logic             par_acc_q, par_acc_d;
    logic             par_err_q, par_err_d;
`endif

    // dir=0 shifts toward bit 0 (first bit lands in bit 0); dir=1 shifts toward the MSB.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                  input logic b,
                                                  input logic msb_first);
        if (msb_first) return {sr[WIDTH-2:0], b};
        else           return {b, sr[WIDTH-1:1]};
    endfunction

    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] sr_first;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] word;
    logic             data_bit;
    logic             out_free;

    assign sr_shift = shift_in(sr_q, sin, dir_q);
    assign sr_first = shift_in('0, sin, dir);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign out_free = ~out_valid_q | out_ready;
`ifdef PES_RX_PARITY_EN
    assign data_bit = (cnt_q < DATA_CNT);
    assign word     = sr_q;
`else
    assign data_bit = 1'b1;
    assign word     = sr_shift;
`endif

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_frame_d = 1'b0;
        err_ovr_d   = 1'b0;
`ifdef PES_RX_PARITY_EN
        par_acc_d   = par_acc_q;
        par_err_d   = par_err_q;
`endif

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (sin_vld) begin
            if (sof) begin
                // A sof always opens a fresh word; inside RECV it also aborts the partial one.
                err_frame_d = (state_q == RECV);
                dir_d       = dir;
                sr_d        = sr_first;
                cnt_d       = CNT_W'(1);
                state_d     = RECV;
`ifdef PES_RX_PARITY_EN
                par_acc_d   = sin;
`endif
            end else if (state_q == RECV) begin
                if (data_bit) sr_d = sr_shift;
                cnt_d = cnt_inc;
`ifdef PES_RX_PARITY_EN
                par_acc_d = par_acc_q ^ sin;
`endif
                if (cnt_inc == FRAME_LEN) begin
                    if (out_free) begin
                        out_data_d  = word;
                        out_valid_d = 1'b1;
`ifdef PES_RX_PARITY_EN
                        par_err_d   = par_acc_q ^ sin;
`endif
                    end else begin
                        err_ovr_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_frame_q <= 1'b0;
            err_ovr_q   <= 1'b0;
`ifdef PES_RX_PARITY_EN
            par_acc_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_frame_q <= err_frame_d;
            err_ovr_q   <= err_ovr_d;
`ifdef PES_RX_PARITY_EN
            par_acc_q   <= par_acc_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == RECV);
    assign err_frame = err_frame_q;
    assign err_ovr   = err_ovr_q;
`ifdef PES_RX_PARITY_EN
    assign par_err   = par_err_q;
`else
    assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pes_sipo_rx.sv
// Directed bench for pes_sipo_rx (WIDTH=4); follows PES_RX_PARITY_EN if defined.
module tb_pes_sipo_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin, sin_vld, sof, dir, out_ready;
    logic [3:0] out_data;
    logic       out_valid, busy, err_frame, err_ovr, par_err;
    int         total = 0;
    int         bad   = 0;

    pes_sipo_rx #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .sof(sof), .dir(dir),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err_frame(err_frame), .err_ovr(err_ovr), .par_err(par_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one accepted bit for one edge, then sample 1 time unit after it.
    task automatic bit_in(input logic b, input logic s, input logic d);
        sin = b; sof = s; dir = d; sin_vld = 1'b1;
        @(posedge clk); #1;
        sin_vld = 1'b0; sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic par_bit(input logic p);
`ifdef PES_RX_PARITY_EN
        bit_in(p, 1'b0, 1'b0);
`endif
    endtask

    task automatic send_frame(input logic [3:0] w, input logic d);
        for (int i = 0; i < 4; i++)
            bit_in(d ? w[3-i] : w[i], (i == 0), d);
        par_bit(^w);
    endtask

    initial begin
        rst = 1'b1; sin = 0; sin_vld = 0; sof = 0; dir = 0; out_ready = 0;
        idle(2);
        chk("rst_valid", 16'(out_valid), 16'h0);
        chk("rst_data",  16'(out_data),  16'h0);
        chk("rst_busy",  16'(busy),      16'h0);
        chk("rst_errs",  16'({err_frame, err_ovr, par_err}), 16'h0);
        rst = 1'b0;
        idle(1);

        // Stray inputs in IDLE are ignored
        sof = 1'b1; sin = 1'b1; idle(1); sof = 1'b0;
        chk("idle_sof_novld", 16'(busy), 16'h0);
        bit_in(1'b1, 1'b0, 1'b0);
        chk("idle_nosof", 16'(busy), 16'h0);

        // 1: LSB-first 1,0,1,1 -> D
        out_ready = 1'b1;
        bit_in(1, 1, 0);
        chk("t1_busy", 16'(busy), 16'h1);
        bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0);
        par_bit(1'b1);
        chk("t1_valid", 16'(out_valid), 16'h1);
        chk("t1_data",  16'(out_data),  16'hD);
        chk("t1_busy_end", 16'(busy), 16'h0);
        chk("t1_errs", 16'({err_frame, err_ovr}), 16'h0);
        chk("t1_par", 16'(par_err), 16'h0);
        idle(1);
        chk("t1_valid_drop", 16'(out_valid), 16'h0);

        // 2: MSB-first 1,0,1,1 with gaps -> B
        bit_in(1, 1, 1); idle(1);
        chk("t2_busy_gap1", 16'(busy), 16'h1);
        bit_in(0, 0, 0); idle(3);
        chk("t2_busy_gap3", 16'(busy), 16'h1);
        bit_in(1, 0, 0); idle(2);
        chk("t2_busy_gap2", 16'(busy), 16'h1);
        chk("t2_novalid_yet", 16'(out_valid), 16'h0);
        bit_in(1, 0, 0);
        par_bit(1'b1);
        chk("t2_valid", 16'(out_valid), 16'h1);
        chk("t2_data",  16'(out_data),  16'hB);
        idle(1);

        // 3: mid-word sof -> err_frame once, word C
        bit_in(1, 1, 0); bit_in(0, 0, 0);
        chk("t3_noerr_pre", 16'(err_frame), 16'h0);
        bit_in(0, 1, 0);
        chk("t3_err_frame", 16'(err_frame), 16'h1);
        chk("t3_busy", 16'(busy), 16'h1);
        bit_in(0, 0, 0);
        chk("t3_err_pulse", 16'(err_frame), 16'h0);
        bit_in(1, 0, 0);
        chk("t3_novalid_yet", 16'(out_valid), 16'h0);
        bit_in(1, 0, 0);
        par_bit(1'b0);
        chk("t3_valid", 16'(out_valid), 16'h1);
        chk("t3_data",  16'(out_data),  16'hC);
        idle(1);
        chk("t3_valid_once", 16'(out_valid), 16'h0);

        // 4: backpressure -> overrun on second word, D held
        out_ready = 1'b0;
        send_frame(4'hD, 1'b0);
        chk("t4_valid1", 16'(out_valid), 16'h1);
        chk("t4_data1",  16'(out_data),  16'hD);
        send_frame(4'h3, 1'b0);
        chk("t4_err_ovr", 16'(err_ovr), 16'h1);
        chk("t4_data_held", 16'(out_data), 16'hD);
        chk("t4_valid_held", 16'(out_valid), 16'h1);
        idle(1);
        chk("t4_ovr_pulse", 16'(err_ovr), 16'h0);
        out_ready = 1'b1;
        idle(1);
        chk("t4_drained", 16'(out_valid), 16'h0);
        chk("t4_data_after", 16'(out_data), 16'hD);

        // 5: back-to-back 5 then A
        send_frame(4'h5, 1'b0);
        chk("t5_data1", 16'(out_data), 16'h5);
        chk("t5_valid1", 16'(out_valid), 16'h1);
        send_frame(4'hA, 1'b0);
        chk("t5_data2", 16'(out_data), 16'hA);
        chk("t5_valid2", 16'(out_valid), 16'h1);
        chk("t5_errs", 16'({err_frame, err_ovr}), 16'h0);
        idle(1);

        // 6: async reset mid-frame, then 9 MSB-first
        bit_in(1, 1, 0); bit_in(0, 0, 0);
        rst = 1'b1; #1;
        chk("t6_busy", 16'(busy), 16'h0);
        chk("t6_data", 16'(out_data), 16'h0);
        chk("t6_valid_errs", 16'({out_valid, err_frame, err_ovr, par_err}), 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_frame(4'h9, 1'b1);
        chk("t6_valid", 16'(out_valid), 16'h1);
        chk("t6_data9", 16'(out_data), 16'h9);
        chk("t6_noerr", 16'(err_frame), 16'h0);
        idle(1);

`ifdef PES_RX_PARITY_EN
        // Parity: D with parity 1 is clean, parity 0 is flagged
        bit_in(1, 1, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0);
        chk("par_ok_data", 16'(out_data), 16'hD);
        chk("par_ok", 16'(par_err), 16'h0);
        bit_in(1, 1, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(0, 0, 0);
        chk("par_bad", 16'(par_err), 16'h1);
        idle(1);
`else
        chk("par_tied", 16'(par_err), 16'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
